down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
Loadable down-counting timer with prescaler and terminal-count signalling. It is the count-down counterpart of the team's enable-gated up counter. Software or an FSM loads a start value, and the block decrements it on prescaled enable ticks. It flags terminal count either once (one-shot) or repeatedly with auto-reload (periodic). Used for delays, Vbuddy display timing and periodic event generation.

Parameters:
WIDTH, 8, width of count, load value and reload register
PRESCALE_W, 16, width of prescaler compare value and prescaler counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ld  input  1  load strobe; captures v, mode and prescale and (re)starts the timer
v  input  WIDTH  start/reload value
mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled only on ld
prescale  input  PRESCALE_W  steps occur every (prescale+1) enabled cycles; sampled only on ld
en  input  1  count enable; 0 pauses the timer (count and prescaler frozen)
count  output  WIDTH  current count value
tc  output  1  terminal-count pulse, exactly one cycle wide
busy  output  1  high while in RUN
done  output  1  high while in DONE (one-shot expired)

Behaviour:
- Reset: rst (clk, synchronous, active-high) overrides everything.
  - state = IDLE; count = 0, tc = 0, busy = 0, done = 0.
  - Internal reload register, latched mode, latched prescale and prescaler counter pcnt all cleared to 0.
- All outputs are registered. busy = (state == RUN). done = (state == DONE).
- States are IDLE, RUN and DONE.
- Priority: rst > ld > en-driven activity.
- ld, in any state, takes effect on the next edge:
  - count <= v; reload <= v.
  - Latches mode and prescale; pcnt <= 0; tc <= 0.
  - If v != 0, go to RUN; if v == 0, go to IDLE with count = 0 and no tc.
  - ld during RUN restarts cleanly and discards any partial prescale.
- IDLE: holds count; en is ignored.
- RUN, en = 0: count, pcnt and state are held; tc = 0.
- RUN, en = 1, pcnt != prescale_latched: pcnt <= pcnt + 1; no step.
- RUN, en = 1, pcnt == prescale_latched: this is a step, and pcnt <= 0.
  - prescale = 0 therefore steps on every enabled cycle.
- Step when count > 1: count <= count - 1.
- Step when count == 1, one-shot: count <= 0; tc <= 1; state <= DONE.
- Step when count == 1, periodic: count <= reload; tc <= 1; stay in RUN.
  - count never shows 0 in periodic mode.
  - Period = reload × (prescale + 1) enabled cycles.
- tc is high only in the cycle directly after a terminal step edge; otherwise 0.
  - With prescale = 0 and en held, periodic mode gives one tc every reload cycles.
- DONE: count = 0 and done = 1 are held until ld or rst; en is ignored.
- Arithmetic is unsigned and modulo-free: a decrement below 1 never occurs in RUN, so there is no wrap to all-ones.
- v = all-ones is legal and gives the maximum 2^WIDTH - 1 steps.
- Simultaneous ld and a terminal step: ld wins, and no tc is produced.
- Reset mid-RUN: the next cycle is fully reset state, and no tc is produced.

Test Plan:
- Reset: hold rst 2 cycles with ld = 1, v = 8'h55 -> count = 0, tc = 0, busy = 0, done = 0 after release; state IDLE.
- One-shot: ld with v = 3, mode = 0, prescale = 0, then en = 1 -> count goes 3, 2, 1, 0 on consecutive edges; tc is 1 in the single cycle count first reads 0; then done = 1 and busy = 0; count stays 0 for 10 more en cycles.
- Periodic: ld with v = 4, mode = 1, prescale = 0, en = 1 for 12 cycles -> count sequence 4, 3, 2, 1, 4, 3, 2, 1, 4, ...; tc pulses every 4 cycles, 3 pulses total; count is never 0.
- Prescale and pause: ld with v = 2, mode = 0, prescale = 2, en = 1 -> one step per 3 cycles, so tc comes 6 cycles after ld. Repeat with en = 0 for 5 cycles mid-run -> tc is delayed by exactly 5 cycles and count is frozen during the pause.
- Restart and collision: periodic v = 2 running; assert ld with v = 5 on the cycle a terminal step would occur -> no tc, count = 5 next cycle. ld with v = 0 -> IDLE, count = 0, busy = 0, no tc.
- Max value: WIDTH = 8, ld with v = 8'hFF, mode = 0, prescale = 0, en = 1 -> exactly 255 steps to tc, with no wrap to 8'hFF after reaching 0.

Source files
------------

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable prescaled down counter with one-shot or periodic terminal count
module down_counter_timer #(
   parameter int WIDTH = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld,
   input  logic [WIDTH-1:0]      v,
   input  logic                  mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  en,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] count_n, reload, reload_n;
   logic [PRESCALE_W-1:0] pre, pre_n, pcnt, pcnt_n;
   logic per, per_n, tc_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         pre    <= '0;
         pcnt   <= '0;
         per    <= 1'b0;
         tc     <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         reload <= reload_n;
         pre    <= pre_n;
         pcnt   <= pcnt_n;
         per    <= per_n;
         tc     <= tc_n;
      end
   end
   // A step only happens in RUN with en, once the prescaler reaches its compare value
   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      pre_n    = pre;
      pcnt_n   = pcnt;
      per_n    = per;
      tc_n     = 1'b0;
      if (ld) begin
         count_n  = v;
         reload_n = v;
         pre_n    = prescale;
         per_n    = mode;
         pcnt_n   = '0;
         state_n  = (v != '0) ? RUN : IDLE;
      end else if (state == RUN && en) begin
         pcnt_n = (pcnt == pre) ? '0 : pcnt + PRESCALE_W'(1);
         if (pcnt == pre) begin
            tc_n    = (count == WIDTH'(1));
            count_n = (count != WIDTH'(1)) ? count - WIDTH'(1) : per ? reload : '0;
            state_n = (count == WIDTH'(1) && !per) ? DONE : RUN;
         end
      end
   end
   assign busy = (state == RUN);
   assign done = (state == DONE);
endmodule
